// File: rtl/rv_iommu_wsi_gen_pkg.sv
// Shared types and constants for the IOMMU wired-signaled interrupt generator.
package rv_iommu_wsi_gen_pkg;

    // Wire signalling mode selected by the register file
    typedef enum logic {
        WSI_MODE_LEVEL = 1'b0,
        WSI_MODE_PULSE = 1'b1
    } wsi_mode_e;

    // Per-vector pulse generator states
    typedef enum logic [1:0] {
        WSI_IDLE  = 2'd0,
        WSI_PULSE = 2'd1,
        WSI_GAP   = 2'd2
    } wsi_state_e;

    // Interrupt source indices
    localparam int unsigned SRC_CQ  = 0;
    localparam int unsigned SRC_FQ  = 1;
    localparam int unsigned SRC_HPM = 2;
    localparam int unsigned SRC_PQ  = 3;

    // Pulse width counter width
    localparam int unsigned CNT_W = 8;

    // Vector index width: at least one bit even for a single wire
    function automatic int unsigned vec_width(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rv_iommu_wsi_pulse.sv
// One interrupt wire: follows the level input in level mode, or emits
// fixed-width pulses with a single queued retrigger in pulse mode.
module rv_iommu_wsi_pulse
    import rv_iommu_wsi_gen_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic mode_i,
    input  logic mode_chg_i,
    input  logic trig_i,
    input  logic lvl_i,
    output logic wire_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);

    wsi_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retrig_q;

    // Wire state machine; disable or a mode switch forces it back to idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= WSI_IDLE;
            cnt_q    <= '0;
            retrig_q <= 1'b0;
            wire_o   <= 1'b0;
        end else if (!en_i || mode_chg_i || (wsi_mode_e'(mode_i) == WSI_MODE_LEVEL)) begin
            state_q  <= WSI_IDLE;
            cnt_q    <= '0;
            retrig_q <= 1'b0;
            wire_o   <= en_i & (wsi_mode_e'(mode_i) == WSI_MODE_LEVEL) & lvl_i;
        end else begin
            case (state_q)
                WSI_IDLE: begin
                    if (trig_i) begin
                        state_q <= WSI_PULSE;
                        cnt_q   <= CNT_LOAD;
                        wire_o  <= 1'b1;
                    end else begin
                        wire_o  <= 1'b0;
                    end
                end
                WSI_PULSE: begin
                    if (trig_i) begin
                        retrig_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q <= WSI_GAP;
                        wire_o  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        wire_o  <= 1'b1;
                    end
                end
                WSI_GAP: begin
                    // A trigger landing in the gap itself also counts as queued
                    if (retrig_q || trig_i) begin
                        state_q  <= WSI_PULSE;
                        cnt_q    <= CNT_LOAD;
                        retrig_q <= 1'b0;
                        wire_o   <= 1'b1;
                    end else begin
                        state_q  <= WSI_IDLE;
                        wire_o   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= WSI_IDLE;
                    cnt_q    <= '0;
                    retrig_q <= 1'b0;
                    wire_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/rv_iommu_wsi_gen.sv
// Maps IOMMU interrupt sources onto wired-signaled interrupt lines,
// tracking per-source pending bits for ipsr readback.
module rv_iommu_wsi_gen
    import rv_iommu_wsi_gen_pkg::*;
#(
    parameter  int unsigned N_INT_VEC    = 16,
    parameter  int unsigned N_SRC        = 4,
    parameter  int unsigned PULSE_CYCLES = 4,
    localparam int unsigned VEC_W        = vec_width(N_INT_VEC)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wsi_en_i,
    input  logic                   mode_i,
    input  logic [N_SRC-1:0]       src_ip_i,
    input  logic [N_SRC*VEC_W-1:0] src_vec_i,
    input  logic [N_SRC-1:0]       src_clr_i,
    output logic [N_SRC-1:0]       pend_o,
    output logic [N_INT_VEC-1:0]   wsi_wires_o
);

    logic [N_SRC-1:0]     src_ip_q;
    logic                 mode_q;
    logic [N_SRC-1:0]     rise_c;
    logic                 mode_chg_c;
    logic [N_INT_VEC-1:0] trig_c;
    logic [N_INT_VEC-1:0] lvl_c;

    assign rise_c     = src_ip_i & ~src_ip_q;
    assign mode_chg_c = mode_i ^ mode_q;

    // Source history, mode history and pending bits (set beats clear)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_ip_q <= '0;
            mode_q   <= 1'b0;
            pend_o   <= '0;
        end else begin
            src_ip_q <= src_ip_i;
            mode_q   <= mode_i;
            for (int unsigned s = 0; s < N_SRC; s++) begin
                if (rise_c[s]) begin
                    pend_o[s] <= 1'b1;
                end else if (src_clr_i[s]) begin
                    pend_o[s] <= 1'b0;
                end else if ((wsi_mode_e'(mode_i) == WSI_MODE_LEVEL) && !src_ip_i[s]) begin
                    pend_o[s] <= 1'b0;
                end
            end
        end
    end

    // Gather triggers and pending levels per vector; out-of-range indices never match
    always_comb begin
        trig_c = '0;
        lvl_c  = '0;
        for (int unsigned v = 0; v < N_INT_VEC; v++) begin
            for (int unsigned s = 0; s < N_SRC; s++) begin
                if (32'(src_vec_i[s*VEC_W +: VEC_W]) == v) begin
                    trig_c[v] = trig_c[v] | rise_c[s];
                    lvl_c[v]  = lvl_c[v]  | pend_o[s];
                end
            end
        end
    end

    // One wire generator per vector
    for (genvar v = 0; v < N_INT_VEC; v++) begin : g_vec
        rv_iommu_wsi_pulse #(
            .PULSE_CYCLES (PULSE_CYCLES)
        ) u_pulse (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .en_i       (wsi_en_i),
            .mode_i     (mode_i),
            .mode_chg_i (mode_chg_c),
            .trig_i     (trig_c[v]),
            .lvl_i      (lvl_c[v]),
            .wire_o     (wsi_wires_o[v])
        );
    end

endmodule

// File: tb/tb_rv_iommu_wsi_gen.sv
// Bench for rv_iommu_wsi_gen: directed scenarios plus random traffic,
// checked every cycle against a behavioural model.
module tb_rv_iommu_wsi_gen;

    localparam int NV = 12;   // non power of two so indices 12..15 are out of range
    localparam int NS = 4;
    localparam int PC = 4;
    localparam int VW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            wsi_en;
    logic            mode;
    logic [NS-1:0]   src_ip;
    logic [NS*VW-1:0] src_vec;
    logic [NS-1:0]   src_clr;
    logic [NS-1:0]   pend;
    logic [NV-1:0]   wires;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [NS-1:0] m_ipq;
    logic [NS-1:0] m_pend;
    logic          m_modeq;
    logic [NV-1:0] m_wire;
    int            m_phase [NV];  // -1 idle, 0..PC-1 high cycle index, PC gap
    bit            m_q     [NV];

    int hi, rises, gap, w, prev;

    always #5 clk = ~clk;

    rv_iommu_wsi_gen #(
        .N_INT_VEC    (NV),
        .N_SRC        (NS),
        .PULSE_CYCLES (PC)
    ) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .wsi_en_i    (wsi_en),
        .mode_i      (mode),
        .src_ip_i    (src_ip),
        .src_vec_i   (src_vec),
        .src_clr_i   (src_clr),
        .pend_o      (pend),
        .wsi_wires_o (wires)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ipq   = '0;
        m_pend  = '0;
        m_modeq = 1'b0;
        m_wire  = '0;
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = -1;
            m_q[v]     = 1'b0;
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_update();
        logic [NS-1:0] rise, np;
        logic [NV-1:0] trig, lvl, nw;
        int vv;
        rise = src_ip & ~m_ipq;
        trig = '0;
        lvl  = '0;
        nw   = '0;
        for (int s = 0; s < NS; s++) begin
            vv = int'(src_vec[s*VW +: VW]);
            if (vv < NV) begin
                if (rise[s])   trig[vv] = 1'b1;
                if (m_pend[s]) lvl[vv]  = 1'b1;
            end
        end
        for (int v = 0; v < NV; v++) begin
            if (!wsi_en || (mode != m_modeq)) begin
                m_phase[v] = -1;
                m_q[v]     = 1'b0;
                nw[v]      = wsi_en & ~mode & lvl[v];
            end else if (!mode) begin
                m_phase[v] = -1;
                nw[v]      = lvl[v];
            end else if (m_phase[v] < 0) begin
                if (trig[v]) m_phase[v] = 0;
                nw[v] = trig[v];
            end else if (m_phase[v] < PC) begin
                if (trig[v]) m_q[v] = 1'b1;
                m_phase[v] = m_phase[v] + 1;
                nw[v] = (m_phase[v] < PC);
            end else begin
                if (m_q[v] || trig[v]) begin
                    m_phase[v] = 0;
                    m_q[v]     = 1'b0;
                    nw[v]      = 1'b1;
                end else begin
                    m_phase[v] = -1;
                    nw[v]      = 1'b0;
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            if (rise[s])                 np[s] = 1'b1;
            else if (src_clr[s])         np[s] = 1'b0;
            else if (!mode && !src_ip[s]) np[s] = 1'b0;
            else                         np[s] = m_pend[s];
        end
        m_pend  = np;
        m_ipq   = src_ip;
        m_modeq = mode;
        m_wire  = nw;
    endtask

    // One clock: model follows the edge, outputs sampled on the falling edge
    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        check("pend", 32'(pend), 32'(m_pend));
        check("wires", 32'(wires), 32'(m_wire));
    endtask

    task automatic set_vec(input int s, input int v);
        src_vec[s*VW +: VW] = VW'(v);
    endtask

    initial begin
        rst_n   = 1'b0;
        wsi_en  = 1'b1;
        mode    = 1'b0;
        src_ip  = '0;
        src_clr = '0;
        src_vec = '0;
        model_reset();
        #1;
        check("reset_pend", 32'(pend), 32'd0);
        check("reset_wires", 32'(wires), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // level mapping with two sources sharing vector 3
        set_vec(0, 3); set_vec(1, 3); set_vec(2, 7); set_vec(3, 15);
        step();
        src_ip[0] = 1'b1;
        step();
        check("lvl_lat1", 32'(wires[3]), 32'd0);
        step();
        check("lvl_lat2", 32'(wires[3]), 32'd1);
        src_ip[1] = 1'b1;
        step();
        src_ip[0] = 1'b0;
        step();
        step();
        check("lvl_shared", 32'(wires[3]), 32'd1);
        src_ip[1] = 1'b0;
        step();
        step();
        check("lvl_drop", 32'(wires[3]), 32'd0);

        // pulse width on vector 7
        mode = 1'b1;
        step();
        step();
        src_ip[2] = 1'b1;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            hi += int'(wires[7]);
        end
        check("pulse_width", 32'(hi), 32'(PC));

        // three extra rises during one pulse collapse into one retrigger
        src_ip = '0;
        set_vec(1, 7); set_vec(3, 7);
        step();
        step();
        src_clr = 4'hF;
        step();
        src_clr = '0;
        hi = 0; rises = 0; gap = 0; prev = 0;
        for (int i = 0; i < 17; i++) begin
            case (i)
                0: src_ip[2] = 1'b1;
                1: src_ip[1] = 1'b1;
                2: src_ip[3] = 1'b1;
                3: src_ip[2] = 1'b0;
                4: src_ip[2] = 1'b1;
                default: ;
            endcase
            step();
            w = int'(wires[7]);
            if (w == 1 && prev == 0) rises++;
            if (rises == 1 && w == 0) gap++;
            hi += w;
            prev = w;
        end
        check("retrig_pulses", 32'(rises), 32'd2);
        check("retrig_gap", 32'(gap), 32'd1);
        check("retrig_high", 32'(hi), 32'(2 * PC));
        check("pulse_pend_kept", 32'(pend[2]), 32'd1);

        // set and clear together: set wins
        mode   = 1'b0;
        src_ip = '0;
        step();
        step();
        src_ip[0]  = 1'b1;
        src_clr[0] = 1'b1;
        step();
        src_clr = '0;
        check("set_wins", 32'(pend[0]), 32'd1);

        // out-of-range vector: pending tracked, no wire
        src_ip = '0;
        step();
        step();
        set_vec(3, 13);
        src_ip[3] = 1'b1;
        step();
        step();
        check("oor_pend", 32'(pend[3]), 32'd1);
        check("oor_wires", 32'(wires), 32'd0);

        // enable toggle in level mode
        src_ip = 4'b0001;
        set_vec(0, 3);
        step();
        step();
        check("en_before", 32'(wires[3]), 32'd1);
        wsi_en = 1'b0;
        step();
        check("en_off_wire", 32'(wires), 32'd0);
        check("en_off_pend", 32'(pend[0]), 32'd1);
        step();
        wsi_en = 1'b1;
        step();
        check("en_back", 32'(wires[3]), 32'd1);

        // asynchronous reset in the middle of a pulse
        src_ip = '0;
        mode   = 1'b1;
        step();
        step();
        src_ip[2] = 1'b1;
        step();
        step();
        check("pre_rst_pulse", 32'(wires[7]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wires", 32'(wires), 32'd0);
        check("async_rst_pend", 32'(pend), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // random traffic, including remapping, clears, disables and mode flips
        for (int i = 0; i < 600; i++) begin
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 2) == 0) src_ip[s] = ~src_ip[s];
            end
            if ($urandom_range(0, 15) == 0) src_vec = NS*VW'($urandom);
            src_clr = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
            wsi_en  = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 49) == 0) mode = ~mode;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
